// File: rtl/bsg_fsb_node_multi_buffer.sv
// Routes FSB ring packets into per-node FIFOs by destination id, merges node FIFOs onto the ring via locking round-robin.
// Latency: 1 cycle through each FIFO; backpressure via valid/ready toward nodes and FSB, yumi on the ring output.
`timescale 1ns/1ps

module bsg_fsb_node_multi_buffer_fifo #(
  parameter int width_p = 80,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               enq_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               full_o
);
  localparam int aw = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [aw:0]        wptr, rptr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq_i) wptr <= wptr + 1'b1;
      if (deq_i) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem[wptr[aw-1:0]] <= data_i;
  end

  assign data_o = mem[rptr[aw-1:0]];
  assign v_o    = (wptr != rptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
endmodule

module bsg_fsb_node_multi_buffer #(
  parameter int ring_width_p = 80,
  parameter int num_nodes_p  = 2,
  parameter int fifo_els_p   = 4,
  parameter int id_lsb_p     = 76,
  parameter int id_width_p   = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                R_en_i,
  input  logic                                R_v_i,
  input  logic [ring_width_p-1:0]             R_data_i,
  output logic                                R_ready_o,
  output logic                                R_v_o,
  output logic [ring_width_p-1:0]             R_data_o,
  input  logic                                R_yumi_i,
  output logic [num_nodes_p-1:0]              L_en_o,
  output logic [num_nodes_p-1:0]              L_v_o,
  output logic [num_nodes_p*ring_width_p-1:0] L_data_o,
  input  logic [num_nodes_p-1:0]              L_ready_and_i,
  input  logic [num_nodes_p-1:0]              L_v_i,
  input  logic [num_nodes_p*ring_width_p-1:0] L_data_i,
  output logic [num_nodes_p-1:0]              L_yumi_o,
  output logic [7:0]                          drop_count_o
);
  typedef enum logic {IDLE, LOCKED} state_t;

  logic [id_width_p-1:0] id;
  logic                  bad_id;
  logic                  sel_full;
  logic                  accept;

  logic [num_nodes_p-1:0] r2l_enq, r2l_full, r2l_v;
  logic [num_nodes_p-1:0] l2r_enq, l2r_deq, l2r_full, l2r_v;
  logic [num_nodes_p-1:0][ring_width_p-1:0] l2r_data;

  state_t                state, state_n;
  logic [id_width_p-1:0] ptr, ptr_n, hold_idx, hold_n, search, grant;
  logic                  any_v;

  assign id     = R_data_i[id_lsb_p +: id_width_p];
  assign bad_id = int'(id) >= num_nodes_p;

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < num_nodes_p; i++) begin
      if (id == id_width_p'(i)) sel_full = r2l_full[i];
    end
  end

  assign R_ready_o = reset_n_i & (bad_id | ~sel_full);
  assign accept    = R_v_i & R_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_count_o <= '0;
      L_en_o       <= '0;
    end else begin
      if (accept && bad_id && drop_count_o != 8'hff) drop_count_o <= drop_count_o + 8'd1;
      L_en_o <= {num_nodes_p{R_en_i}};
    end
  end

  for (genvar i = 0; i < num_nodes_p; i++) begin : g_node
    assign r2l_enq[i] = R_v_i & ~bad_id & (id == id_width_p'(i)) & ~r2l_full[i];
    assign l2r_enq[i] = reset_n_i & L_v_i[i] & ~l2r_full[i];

    bsg_fsb_node_multi_buffer_fifo #(.width_p(ring_width_p), .els_p(fifo_els_p)) r2l (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (R_data_i),
      .enq_i     (r2l_enq[i]),
      .deq_i     (r2l_v[i] & L_ready_and_i[i]),
      .data_o    (L_data_o[i*ring_width_p +: ring_width_p]),
      .v_o       (r2l_v[i]),
      .full_o    (r2l_full[i])
    );

    bsg_fsb_node_multi_buffer_fifo #(.width_p(ring_width_p), .els_p(fifo_els_p)) l2r (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (L_data_i[i*ring_width_p +: ring_width_p]),
      .enq_i     (l2r_enq[i]),
      .deq_i     (l2r_deq[i]),
      .data_o    (l2r_data[i]),
      .v_o       (l2r_v[i]),
      .full_o    (l2r_full[i])
    );
  end

  assign L_v_o    = r2l_v;
  assign L_yumi_o = l2r_enq;

  // Round-robin search starts just past the last winner, wrapping around.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    search = ptr;
    for (int k = 1; k <= num_nodes_p; k++) begin
      idx = (int'(ptr) + k) % num_nodes_p;
      if (!found && l2r_v[idx]) begin
        found  = 1'b1;
        search = id_width_p'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      ptr      <= id_width_p'(num_nodes_p - 1);
      hold_idx <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_idx <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_idx;
    l2r_deq = '0;
    any_v   = |l2r_v;
    grant   = (state == LOCKED) ? hold_idx : search;
    if (any_v && R_yumi_i) begin
      l2r_deq[grant] = 1'b1;
      ptr_n          = grant;
      state_n        = IDLE;
    end else if (any_v) begin
      state_n = LOCKED;
      hold_n  = grant;
    end
  end

  assign R_v_o    = any_v;
  assign R_data_o = l2r_data[grant];

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) (R_yumi_i |-> R_v_o));
endmodule

// File: doc/bsg_fsb_node_multi_buffer.md
Name: bsg_fsb_node_multi_buffer

Overview:
- Single-clock, multi-node buffer between one FSB ring port and num_nodes_p node ports.
- FSB to node: incoming ring packets are routed by the destination-id field into per-node FIFOs.
- Node to FSB: per-node FIFOs are merged onto the ring through a locking round-robin arbiter.
- Replaces point-to-point node buffering where several nodes share one FSB slot. Adds an invalid-id drop counter and a registered enable fan-out.

Parameters:
- ring_width_p, 80, packet width in bits.
- num_nodes_p, 2, number of node ports; 1..16.
- fifo_els_p, 4, depth of each per-node FIFO, per direction; a power of 2, minimum 2.
- id_lsb_p, 76, bit position of the destination-id field in a ring packet.
- id_width_p, `BSG_SAFE_CLOG2(num_nodes_p), width of the destination-id field.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- R_en_i  in  1  FSB enable.
- R_v_i  in  1  FSB-to-node packet valid.
- R_data_i  in  ring_width_p  FSB-to-node packet.
- R_ready_o  out  1  FSB-to-node accept (valid/ready).
- R_v_o  out  1  node-to-FSB packet valid.
- R_data_o  out  ring_width_p  node-to-FSB packet.
- R_yumi_i  in  1  FSB consumes R_data_o this cycle.
- L_en_o  out  num_nodes_p  per-node enable, registered copy of R_en_i.
- L_v_o  out  num_nodes_p  per-node packet valid toward the node.
- L_data_o  out  num_nodes_p*ring_width_p  per-node packets; node i occupies slice [i*ring_width_p +: ring_width_p].
- L_ready_and_i  in  num_nodes_p  per-node ready.
- L_v_i  in  num_nodes_p  per-node packet valid toward the FSB.
- L_data_i  in  num_nodes_p*ring_width_p  per-node packets toward the FSB.
- L_yumi_o  out  num_nodes_p  per-node accept (late).
- drop_count_o  out  8  saturating count of packets dropped for an invalid id.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - All FIFOs are emptied.
  - Arbiter pointer = num_nodes_p-1, so node 0 has first priority; grant lock is cleared.
  - drop_count_o = 0; L_en_o = 0.
  - R_v_o = 0; L_v_o = 0; L_yumi_o = 0; R_ready_o = 0.
  - Deassertion takes effect at the next clk_i edge.
- Storage: all FIFOs are synchronous, with 1-cycle latency (data enqueued at edge k is visible after edge k). There is no bypass path. Empty FIFOs present valid low; data outputs are don't-care.
- FSB to node:
  - id = R_data_i[id_lsb_p +: id_width_p].
  - If id < num_nodes_p: R_ready_o = ~full[id]. The packet enqueues into r2l[id] on R_v_i & R_ready_o.
  - If id >= num_nodes_p: R_ready_o = 1. A valid packet is discarded and drop_count_o increments, saturating at 255.
  - R_ready_o depends on R_data_i; the FSB must not make R_v_i depend on R_ready_o.
  - L_v_o[i] = ~empty(r2l[i]). A dequeue occurs on L_v_o[i] & L_ready_and_i[i].
- Node to FSB:
  - L_yumi_o[i] = L_v_i[i] & ~full(l2r[i]).
  - A full FIFO refuses writes even if it is dequeued in the same cycle; there is no full-pass-through.
- Arbitration:
  - Idle state: grant goes to the first non-empty l2r[j], searching from pointer+1 mod num_nodes_p with wrap-around.
  - R_v_o = 1 whenever any l2r FIFO is non-empty.
  - LOCKED state: entered once R_v_o = 1 and R_yumi_i = 0. The granted channel, and therefore R_data_o, is held stable until R_yumi_i.
  - On R_yumi_i: the granted FIFO dequeues, pointer := granted index, lock clears. A new grant may be presented in the next cycle.
  - R_yumi_i is asserted the same cycle R_v_o is seen, so back-to-back packets achieve 1 packet/cycle.
  - R_yumi_i while R_v_o = 0 is illegal and flagged by a simulation assertion.
  - num_nodes_p = 1 degenerates to a single FIFO; the pointer is constant 0.
- L_en_o: all bits take R_en_i registered by one flop stage; there is no synchronizer because the block has a single clock.
- Simultaneous events: enqueue and dequeue on the same non-full, non-empty FIFO leave its count unchanged and both proceed.

Test Plan:
- Reset mid-traffic: drop reset_n_i with 3 entries queued in each FIFO → all valids 0 and drop_count_o = 0 immediately, without waiting for a clock edge. After release, FIFOs are empty and the first grant goes to node 0.
- Routing: num_nodes_p = 2. Send packets with id 0, 1, 0 at 1 per cycle, L_ready_and_i = 2'b11 → node 0 receives packets 1 and 3 in order, node 1 receives packet 2, each 1 cycle after acceptance.
- Backpressure/full: hold L_ready_and_i[1] = 0 and send 5 id-1 packets, fifo_els_p = 4 → the first 4 are accepted and R_ready_o = 0 on the 5th. An interleaved id-0 packet is still accepted.
- Invalid id: num_nodes_p = 3, send id 3 for 260 cycles → R_ready_o stays 1, no node sees the packets, and drop_count_o ends at 255.
- Round-robin fairness: all 4 nodes hold L_v_i high and R_yumi_i = 1 every cycle → R_data_o node order is 0,1,2,3,0,1,… at 1 packet/cycle.
- Lock stability: hold R_yumi_i = 0 for 5 cycles while other nodes become non-empty → R_data_o is unchanged throughout. On R_yumi_i, the next grant goes to granted+1.
